char_ram_arbiter: RTL and testbench

- Shares the single-port character RAM between two requesters: CPU store traffic and VGA character fetches.
- CPU writes are posted into a small FIFO and drained when the RAM is free.
- VGA reads have priority, limited by a starvation guard so CPU writes always drain.
- Sits between the processor/memory-map decode, the VGA controller and the 41-entry character RAM, all on clock_50.

---
 rtl/char_ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_char_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_ram_arbiter.sv
// Arbiter for the shared single-port character RAM: VGA reads win by default, CPU stores
// are posted into a small FIFO, and a stall guard forces a CPU slot so the FIFO always drains.
module char_ram_arbiter #(
    parameter int unsigned CHAR_DEPTH = 41,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_STALL  = 8
) (
    input  logic              clock_50,
    input  logic              n_reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_ovf,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned StallW = $clog2(MAX_STALL + 1);

    localparam logic [ADDR_W-1:0] MaxAddr   = ADDR_W'(CHAR_DEPTH - 1);
    localparam logic [CntW-1:0]   FifoFull  = CntW'(FIFO_DEPTH);
    localparam logic [StallW-1:0] StallMax  = StallW'(MAX_STALL);
    localparam logic [StallW-1:0] StallLast = StallW'(MAX_STALL - 1);

    typedef enum logic [0:0] {StVgaPri, StCpuSlot} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
    logic              ovf_q, ovf_d;
    logic              vga_valid_q;
    logic [DATA_W-1:0] rdata_hold_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic fifo_empty;
    logic push;
    logic cpu_gnt;
    logic forced;

    assign fifo_empty = (count_q == '0);
    assign cpu_ready  = (count_q != FifoFull);
    assign push       = cpu_we && cpu_ready && (cpu_addr <= MaxAddr);
    assign forced     = !fifo_empty && (stall_cnt_q == StallMax);
    assign busy       = !fifo_empty;
    assign cpu_ovf    = ovf_q;
    assign vga_valid  = vga_valid_q;

    // Arbitration; the 8th consecutive VGA grant schedules the CPU slot for the next cycle.
    always_comb begin
        state_d = state_q;
        vga_gnt = 1'b0;
        cpu_gnt = 1'b0;
        unique case (state_q)
            StVgaPri: begin
                if (vga_req && !forced) begin
                    vga_gnt = 1'b1;
                    if (!fifo_empty && stall_cnt_q == StallLast) begin
                        state_d = StCpuSlot;
                    end
                end else if (!fifo_empty) begin
                    cpu_gnt = 1'b1;
                end
            end
            StCpuSlot: begin
                cpu_gnt = !fifo_empty;
                state_d = StVgaPri;
            end
            default: state_d = StVgaPri;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        ovf_d       = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (cpu_gnt) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !cpu_gnt) begin
            count_d = count_q + CntW'(1);
        end else if (!push && cpu_gnt) begin
            count_d = count_q - CntW'(1);
        end

        if (cpu_we && !push) begin
            ovf_d = 1'b1;
        end

        if (cpu_gnt || fifo_empty) begin
            stall_cnt_d = '0;
        end else if (vga_gnt && stall_cnt_q != StallMax) begin
            stall_cnt_d = stall_cnt_q + StallW'(1);
        end
    end

    // Idle cycles keep the last address/data on the RAM bus.
    always_comb begin
        ram_we    = cpu_gnt;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        if (cpu_gnt) begin
            ram_addr  = fifo_addr_q[rd_ptr_q];
            ram_wdata = fifo_data_q[rd_ptr_q];
        end else if (vga_gnt) begin
            ram_addr = vga_addr;
        end
    end

    // ram_rdata is the RAM's own output register; pass it through only while it is valid.
    always_comb begin
        vga_rdata = rdata_hold_q;
        if (vga_valid_q) begin
            vga_rdata = ram_rdata;
        end
    end

    always_ff @(posedge clock_50 or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= StVgaPri;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            stall_cnt_q  <= '0;
            ovf_q        <= 1'b0;
            vga_valid_q  <= 1'b0;
            rdata_hold_q <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            stall_cnt_q  <= stall_cnt_d;
            ovf_q        <= ovf_d;
            vga_valid_q  <= vga_gnt;
            rdata_hold_q <= vga_rdata;
            ram_addr_q   <= ram_addr;
            ram_wdata_q  <= ram_wdata;
        end
    end

    always_ff @(posedge clock_50) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed bench for char_ram_arbiter with a behavioural synchronous RAM behind it.
module tb_char_ram_arbiter;

    logic       clock_50;
    logic       n_reset;
    logic       cpu_we;
    logic [5:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic       cpu_ovf;
    logic       vga_req;
    logic [5:0] vga_addr;
    logic       vga_gnt;
    logic       vga_valid;
    logic [7:0] vga_rdata;
    logic [5:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram_rdata;
    logic       busy;

    int unsigned n_vec;
    int unsigned n_err;

    logic [7:0] mem [64];
    logic       mem_init;

    char_ram_arbiter dut (
        .clock_50  (clock_50),
        .n_reset   (n_reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_ovf   (cpu_ovf),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_gnt   (vga_gnt),
        .vga_valid (vga_valid),
        .vga_rdata (vga_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    // Read-before-write synchronous RAM; entry i preloads to i, except entry 7 = 0x5A.
    always @(posedge clock_50) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 7) ? 8'h5A : 8'(i);
            end
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_50);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_reset = 1'b0;
        mem_init = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        vga_req = 1'b0;
        vga_addr = '0;

        // Reset state
        step();
        step();
        check_eq("rst_ready", 32'(cpu_ready), 32'd1);
        check_eq("rst_ovf", 32'(cpu_ovf), 32'd0);
        check_eq("rst_valid", 32'(vga_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_eq("rst_rdata", 32'(vga_rdata), 32'd0);
        mem_init = 1'b0;
        n_reset = 1'b1;
        step();

        // CPU-only write: not eligible in the push cycle, retires the next
        cpu_we = 1'b1;
        cpu_addr = 6'd5;
        cpu_wdata = 8'h41;
        #1;
        check_eq("wr_same_cycle_we", 32'(ram_we), 32'd0);
        step();
        cpu_we = 1'b0;
        #1;
        check_eq("wr_busy", 32'(busy), 32'd1);
        check_eq("wr_ram_we", 32'(ram_we), 32'd1);
        check_eq("wr_ram_addr", 32'(ram_addr), 32'd5);
        check_eq("wr_ram_wdata", 32'(ram_wdata), 32'h41);
        step();
        check_eq("wr_busy_fall", 32'(busy), 32'd0);
        check_eq("wr_idle_we", 32'(ram_we), 32'd0);
        check_eq("wr_idle_addr_hold", 32'(ram_addr), 32'd5);
        check_eq("wr_mem5", 32'(mem[5]), 32'h41);

        // Back-to-back VGA reads of 7 then 5
        vga_req = 1'b1;
        vga_addr = 6'd7;
        #1;
        check_eq("rd_gnt", 32'(vga_gnt), 32'd1);
        check_eq("rd_ram_addr", 32'(ram_addr), 32'd7);
        check_eq("rd_ram_we", 32'(ram_we), 32'd0);
        step();
        vga_addr = 6'd5;
        #1;
        check_eq("rd2_gnt", 32'(vga_gnt), 32'd1);
        check_eq("rd_valid", 32'(vga_valid), 32'd1);
        check_eq("rd_rdata7", 32'(vga_rdata), 32'h5A);
        step();
        vga_req = 1'b0;
        #1;
        check_eq("rd2_valid", 32'(vga_valid), 32'd1);
        check_eq("rd2_rdata5", 32'(vga_rdata), 32'h41);
        step();
        check_eq("rd_valid_drop", 32'(vga_valid), 32'd0);

        // Overflow: 5 pushes under continuous VGA traffic
        vga_req = 1'b1;
        vga_addr = 6'd3;
        for (int i = 0; i < 5; i++) begin
            cpu_we = 1'b1;
            cpu_addr = 6'(10 + i);
            cpu_wdata = 8'(8'h60 + i);
            #1;
            check_eq($sformatf("ovf_ready_%0d", i), 32'(cpu_ready), (i < 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("ovf_vga_gnt_%0d", i), 32'(vga_gnt), 32'd1);
            step();
        end
        cpu_we = 1'b0;
        #1;
        check_eq("ovf_flag", 32'(cpu_ovf), 32'd1);
        check_eq("ovf_ready_low", 32'(cpu_ready), 32'd0);
        check_eq("ovf_busy", 32'(busy), 32'd1);
        vga_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_eq($sformatf("drain_we_%0d", j), 32'(ram_we), 32'd1);
            check_eq($sformatf("drain_addr_%0d", j), 32'(ram_addr), 32'(10 + j));
            step();
        end
        check_eq("drain_busy", 32'(busy), 32'd0);
        check_eq("drain_ovf_sticky", 32'(cpu_ovf), 32'd1);
        check_eq("drain_ready", 32'(cpu_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("drain_mem_%0d", 10 + k), 32'(mem[10 + k]),
                     (k < 4) ? 32'(8'h60 + k) : 32'd14);
        end

        // Starvation guard: one queued write behind continuous VGA requests
        cpu_we = 1'b1;
        cpu_addr = 6'd20;
        cpu_wdata = 8'h77;
        vga_req = 1'b1;
        vga_addr = 6'd3;
        #1;
        check_eq("stv_gnt_push", 32'(vga_gnt), 32'd1);
        step();
        cpu_we = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            check_eq($sformatf("stv_vga_gnt_%0d", c), 32'(vga_gnt), 32'd1);
            check_eq($sformatf("stv_vga_we_%0d", c), 32'(ram_we), 32'd0);
            step();
        end
        #1;
        check_eq("stv_slot_gnt", 32'(vga_gnt), 32'd0);
        check_eq("stv_slot_we", 32'(ram_we), 32'd1);
        check_eq("stv_slot_addr", 32'(ram_addr), 32'd20);
        check_eq("stv_slot_wdata", 32'(ram_wdata), 32'h77);
        check_eq("stv_slot_valid", 32'(vga_valid), 32'd1);
        step();
        check_eq("stv_resume_gnt", 32'(vga_gnt), 32'd1);
        check_eq("stv_resume_valid", 32'(vga_valid), 32'd0);
        check_eq("stv_resume_busy", 32'(busy), 32'd0);
        vga_req = 1'b0;
        step();

        // Asynchronous reset mid-cycle while a read result is being returned
        vga_req = 1'b1;
        vga_addr = 6'd7;
        step();
        vga_req = 1'b0;
        #1;
        check_eq("arst_pre_valid", 32'(vga_valid), 32'd1);
        #1;
        n_reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(vga_valid), 32'd0);
        check_eq("arst_ovf", 32'(cpu_ovf), 32'd0);
        check_eq("arst_rdata", 32'(vga_rdata), 32'd0);
        check_eq("arst_ready", 32'(cpu_ready), 32'd1);
        #1;
        n_reset = 1'b1;
        step();

        // Out-of-range address 41 is dropped
        cpu_we = 1'b1;
        cpu_addr = 6'd41;
        cpu_wdata = 8'h99;
        step();
        cpu_we = 1'b0;
        #1;
        check_eq("oor_ovf", 32'(cpu_ovf), 32'd1);
        check_eq("oor_busy", 32'(busy), 32'd0);
        check_eq("oor_ram_we", 32'(ram_we), 32'd0);

        // Reset mid-drain: queue 40,1,2 under VGA traffic, reset after the first retires
        vga_req = 1'b1;
        vga_addr = 6'd3;
        cpu_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = (i == 0) ? 6'd40 : 6'(i);
            cpu_wdata = 8'(8'hA0 + i);
            step();
        end
        cpu_we = 1'b0;
        vga_req = 1'b0;
        #1;
        check_eq("mid_first_we", 32'(ram_we), 32'd1);
        check_eq("mid_first_addr", 32'(ram_addr), 32'd40);
        step();
        check_eq("mid_second_addr", 32'(ram_addr), 32'd1);
        #1;
        n_reset = 1'b0;
        #1;
        check_eq("mid_rst_we", 32'(ram_we), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        step();
        n_reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("mid_post_we_%0d", c), 32'(ram_we), 32'd0);
            check_eq($sformatf("mid_post_busy_%0d", c), 32'(busy), 32'd0);
        end
        check_eq("mid_mem40", 32'(mem[40]), 32'hA0);
        check_eq("mid_mem1", 32'(mem[1]), 32'd1);
        check_eq("mid_mem2", 32'(mem[2]), 32'd2);
        check_eq("oor_mem41", 32'(mem[41]), 32'd41);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
